// File: rtl/mult_seq_pkg.sv
// Shared constants for the operand-RAM / multiplier sequencer: mode codes,
// FSM state encodings and the default datapath width.
package mult_seq_pkg;

  localparam int DEFAULT_DATA_W = 32;

  localparam logic [1:0] MODE_U8  = 2'b00;
  localparam logic [1:0] MODE_S8  = 2'b01;
  localparam logic [1:0] MODE_ILL = 2'b10;
  localparam logic [1:0] MODE_S16 = 2'b11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_FETCH  = 3'd1;
  localparam state_t ST_RDWAIT = 3'd2;
  localparam state_t ST_MULW   = 3'd3;
  localparam state_t ST_OUT    = 3'd4;
  localparam state_t ST_DONE   = 3'd5;

  function automatic logic mode_is_legal(input logic [1:0] m);
    return m != MODE_ILL;
  endfunction

endpackage

// File: rtl/mult_seq_outreg.sv
// Result holding register between the sequencer and its downstream consumer.
module mult_seq_outreg #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              fire
);

  // Handshake: data/valid stay frozen while valid=1 and ready=0; a transfer
  // happens on the rising edge where valid & ready are both 1, after which
  // valid drops. load is only asserted while nothing is pending.
  assign fire = valid & ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (fire) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/mult_sequencer.sv
// Walks a RAM window, lets the selected multiplier settle and hands each product
// downstream. Define MULT_SEQ_ACC_EN to add the running-sum output acc_out.
module mult_sequencer
  import mult_seq_pkg::*;
#(
  parameter int MULT_LAT = 0,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [1:0]        mul_sel,
  input  logic [DATA_W-1:0] product,
  output logic [DATA_W-1:0] res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              err_mode
`ifdef MULT_SEQ_ACC_EN
  ,
  output logic [DATA_W-1:0] acc_out
`endif
);

  localparam int LAT_W = $clog2(MULT_LAT + 2);

  state_t            state;
  logic [ADDR_W:0]   steps;
  logic [LAT_W-1:0]  lat_cnt;
  logic              load;
  logic              fire;

  // Operands run straight from the RAM into the multiplier; only their timing matters here.
  logic unused_ops;
  assign unused_ops = ^{op_a, op_b};

  always_comb begin
    load = 1'b0;
    if (state == ST_RDWAIT && MULT_LAT == 0) load = 1'b1;
    if (state == ST_MULW && lat_cnt == LAT_W'(1)) load = 1'b1;
  end

  mult_seq_outreg #(.DATA_W(DATA_W)) u_outreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (product),
    .ready     (res_ready),
    .data      (res_data),
    .valid     (res_valid),
    .fire      (fire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      ram_addr <= '0;
      mul_sel  <= MODE_U8;
      steps    <= '0;
      lat_cnt  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_mode <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            err_mode <= 1'b0;
            steps    <= count;
            if (!mode_is_legal(mode)) begin
              err_mode <= 1'b1;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else if (count == '0) begin
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              ram_addr <= base_addr;
              mul_sel  <= mode;
              state    <= ST_FETCH;
            end
          end
        end
        ST_FETCH: state <= ST_RDWAIT;
        ST_RDWAIT: begin
          if (MULT_LAT == 0) begin
            state <= ST_OUT;
          end else begin
            lat_cnt <= LAT_W'(MULT_LAT);
            state   <= ST_MULW;
          end
        end
        ST_MULW: begin
          lat_cnt <= lat_cnt - 1'b1;
          if (lat_cnt == LAT_W'(1)) state <= ST_OUT;
        end
        ST_OUT: begin
          if (fire) begin
            if (steps == (ADDR_W + 1)'(1)) begin
              steps <= '0;
              done  <= 1'b1;
              state <= ST_DONE;
            end else begin
              // Address wraps naturally at 2^ADDR_W.
              ram_addr <= ram_addr + 1'b1;
              steps    <= steps - 1'b1;
              state    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULT_SEQ_ACC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_out <= '0;
    end else if (state == ST_IDLE && start) begin
      acc_out <= '0;
    end else if (fire) begin
      acc_out <= acc_out + res_data;
    end
  end
`endif

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: two instances (MULT_LAT 0 and 2) share stimulus,
// each with its own registered-read RAM model and multiplier model.
module tb_mult_sequencer;
  import mult_seq_pkg::*;

  localparam int AW   = 4;
  localparam int DW   = 32;
  localparam int W    = AW + DW;
  localparam int LAT0 = 0;
  localparam int LAT1 = 2;

  // ---------------- clock / reset / shared stimulus ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          res_ready;

  always #5 clk = ~clk;

  // ---------------- per-instance signals ----------------
  logic [AW-1:0] ram_addr [2];
  logic [DW-1:0] op_a     [2];
  logic [DW-1:0] op_b     [2];
  logic [DW-1:0] product  [2];
  logic [DW-1:0] res_data [2];
  logic [1:0]    mul_sel  [2];
  logic          res_valid[2];
  logic          busy     [2];
  logic          done     [2];
  logic          err_mode [2];
`ifdef MULT_SEQ_ACC_EN
  logic [DW-1:0] acc_out  [2];
`endif

  logic [DW-1:0] mem [16];
  logic [DW-1:0] prod_p1, prod_p2;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int           n_cmp, n_err, cyc;
  int           first_cyc[2], last_hs[2], hs_cnt[2], done_cnt[2];
  bit           timing_on;
  logic [1:0]   cur_mode;
  logic [DW-1:0] held[2];

  mult_sequencer #(.MULT_LAT(LAT0), .ADDR_W(AW), .DATA_W(DW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .ram_addr(ram_addr[0]), .op_a(op_a[0]), .op_b(op_b[0]),
    .mul_sel(mul_sel[0]), .product(product[0]), .res_data(res_data[0]),
    .res_valid(res_valid[0]), .res_ready(res_ready), .busy(busy[0]),
    .done(done[0]), .err_mode(err_mode[0])
`ifdef MULT_SEQ_ACC_EN
    , .acc_out(acc_out[0])
`endif
  );

  mult_sequencer #(.MULT_LAT(LAT1), .ADDR_W(AW), .DATA_W(DW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .base_addr(base_addr),
    .count(count), .ram_addr(ram_addr[1]), .op_a(op_a[1]), .op_b(op_b[1]),
    .mul_sel(mul_sel[1]), .product(product[1]), .res_data(res_data[1]),
    .res_valid(res_valid[1]), .res_ready(res_ready), .busy(busy[1]),
    .done(done[1]), .err_mode(err_mode[1])
`ifdef MULT_SEQ_ACC_EN
    , .acc_out(acc_out[1])
`endif
  );

  function automatic logic [DW-1:0] mul_model(input logic [1:0] sel, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    int sa, sb;
    case (sel)
      MODE_U8:  begin sa = {24'd0, a[7:0]};          sb = {24'd0, b[7:0]};          end
      MODE_S8:  begin sa = {{24{a[7]}}, a[7:0]};     sb = {{24{b[7]}}, b[7:0]};     end
      MODE_S16: begin sa = {{16{a[15]}}, a[15:0]};   sb = {{16{b[15]}}, b[15:0]};   end
      default:  begin sa = 0;                        sb = 0;                        end
    endcase
    return 32'(sa * sb);
  endfunction

  // RAM: registered read of mem[addr] and mem[addr+1], wrapping inside the window.
  always @(posedge clk) begin
    op_a[0] <= mem[ram_addr[0]];
    op_b[0] <= mem[4'(ram_addr[0] + 4'd1)];
    op_a[1] <= mem[ram_addr[1]];
    op_b[1] <= mem[4'(ram_addr[1] + 4'd1)];
    prod_p1 <= mul_model(mul_sel[1], op_a[1], op_b[1]);
    prod_p2 <= prod_p1;
  end

  // Instance 0 sees a combinational multiplier, instance 1 a two-stage one.
  assign product[0] = mul_model(mul_sel[0], op_a[0], op_b[0]);
  assign product[1] = prod_p2;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input int g);
    return (g == 0) ? LAT0 : LAT1;
  endfunction

  task automatic push_exp(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    exp_q0.push_back({addr, data});
    exp_q1.push_back({addr, data});
  endtask

  task automatic clear_run();
    cyc = 0;
    for (int g = 0; g < 2; g++) begin
      first_cyc[g] = -1;
      hs_cnt[g]    = 0;
      done_cnt[g]  = 0;
    end
  endtask

  task automatic sample(input int g);
    logic [W-1:0] e;
    bit           have;
    if (done[g] === 1'b1) done_cnt[g]++;
    if (res_valid[g] === 1'b1) begin
      if (first_cyc[g] < 0) begin
        first_cyc[g] = cyc;
        if (timing_on)
          check_eq($sformatf("first_lat%0d", g), 32'(cyc), 32'(3 + lat_of(g)));
      end
      if (res_ready === 1'b1) begin
        have = (g == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
        if (!have) begin
          check_eq($sformatf("extra_res%0d", g), 32'(res_valid[g]), 32'd0);
        end else begin
          if (g == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check_eq($sformatf("res_data%0d", g), res_data[g], e[DW-1:0]);
          check_eq($sformatf("ram_addr%0d", g), 32'(ram_addr[g]), 32'(e[W-1:DW]));
          check_eq($sformatf("mul_sel%0d", g), 32'(mul_sel[g]), 32'(cur_mode));
          if (timing_on && hs_cnt[g] > 0)
            check_eq($sformatf("hs_gap%0d", g), 32'(cyc - last_hs[g]), 32'(3 + lat_of(g)));
          last_hs[g] = cyc;
          hs_cnt[g]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample(0);
    sample(1);
  endtask

  task automatic check_reset(input string tag);
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("%s_ram_addr%0d", tag, g), 32'(ram_addr[g]), 32'd0);
      check_eq($sformatf("%s_mul_sel%0d", tag, g), 32'(mul_sel[g]), 32'd0);
      check_eq($sformatf("%s_res_data%0d", tag, g), res_data[g], 32'd0);
      check_eq($sformatf("%s_res_valid%0d", tag, g), 32'(res_valid[g]), 32'd0);
      check_eq($sformatf("%s_busy%0d", tag, g), 32'(busy[g]), 32'd0);
      check_eq($sformatf("%s_done%0d", tag, g), 32'(done[g]), 32'd0);
      check_eq($sformatf("%s_err%0d", tag, g), 32'(err_mode[g]), 32'd0);
    end
  endtask

  // ---------------- driver: one complete run with res_ready held high ----------------
  task automatic do_run(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] c);
    clear_run();
    timing_on = 1'b1;
    res_ready = 1'b1;
    if (m != MODE_ILL) cur_mode = m;
    mode      = m;
    base_addr = b;
    count     = c;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    mode      = 2'($urandom_range(0, 3));
    base_addr = 4'($urandom_range(0, 15));
    count     = 5'($urandom_range(0, 16));
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("busy_run%0d", g), 32'(busy[g]), 32'd1);
      check_eq($sformatf("err_start%0d", g), 32'(err_mode[g]), 32'(m == MODE_ILL));
    end
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && cyc < 200) tick();
    tick();
    tick();
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("done_pulses%0d", g), 32'(done_cnt[g]), 32'd1);
      check_eq($sformatf("busy_end%0d", g), 32'(busy[g]), 32'd0);
      check_eq($sformatf("err_end%0d", g), 32'(err_mode[g]), 32'(m == MODE_ILL));
    end
    check_eq("left_q0", 32'(exp_q0.size()), 32'd0);
    check_eq("left_q1", 32'(exp_q1.size()), 32'd0);
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; mode = MODE_U8; base_addr = '0; count = '0;
    res_ready = 1'b0; cur_mode = MODE_U8; timing_on = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[0] = 32'd1;  mem[1] = 32'd22; mem[2] = 32'hFFFF_FFF7; mem[3] = 32'hFFFF_FFF6;
    mem[4] = 32'd9;  mem[5] = 32'd24; mem[6] = 32'd31;        mem[15] = 32'd5;
    clear_run();

    #12;
    check_reset("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push_exp(4'd0, 32'h16);            // 1 * 22
    do_run(MODE_U8, 4'd0, 5'd1);
    push_exp(4'd2, 32'hED5A);          // 247 * 246
    do_run(MODE_U8, 4'd2, 5'd1);
    push_exp(4'd2, 32'h5A);            // -9 * -10
    do_run(MODE_S8, 4'd2, 5'd1);
    push_exp(4'd3, 32'hFFFF_FFA6);     // -10 * 9
    push_exp(4'd4, 32'hD8);            // 9 * 24
    push_exp(4'd5, 32'h2E8);           // 24 * 31
    do_run(MODE_S16, 4'd3, 5'd3);
`ifdef MULT_SEQ_ACC_EN
    check_eq("acc_out0", acc_out[0], 32'h366);
    check_eq("acc_out1", acc_out[1], 32'h366);
`endif
    push_exp(4'd15, 32'h5);            // mem[15] * mem[0]
    push_exp(4'd0, 32'h16);
    do_run(MODE_U8, 4'd15, 5'd2);
    do_run(MODE_U8, 4'd7, 5'd0);
    do_run(MODE_ILL, 4'd0, 5'd1);
    push_exp(4'd0, 32'h16);
    do_run(MODE_U8, 4'd0, 5'd1);

    // Backpressure, ignored start, then reset in the middle of a run.
    clear_run();
    timing_on = 1'b0;
    res_ready = 1'b0;
    cur_mode  = MODE_S8;
    push_exp(4'd4, 32'hD8);
    push_exp(4'd5, 32'h2E8);
    mode = MODE_S8; base_addr = 4'd4; count = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    while (res_valid[1] !== 1'b1 && cyc < 50) tick();
    check_eq("bp_valid1", 32'(res_valid[1]), 32'd1);
    held[0] = res_data[0];
    held[1] = res_data[1];
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        start = 1'b1;
        mode  = MODE_S16;
      end
      tick();
      start = 1'b0;
      for (int g = 0; g < 2; g++) begin
        check_eq($sformatf("bp_hold%0d", g), res_data[g], held[g]);
        check_eq($sformatf("bp_valid%0d", g), 32'(res_valid[g]), 32'd1);
        check_eq($sformatf("bp_mul_sel%0d", g), 32'(mul_sel[g]), 32'(MODE_S8));
        check_eq($sformatf("bp_busy%0d", g), 32'(busy[g]), 32'd1);
      end
    end
    res_ready = 1'b1;
    tick();
    @(posedge clk);
    #1 res_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    rst_n = 1'b0;
    #1;
    check_reset("midrst");
    exp_q0.delete();
    exp_q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    for (int g = 0; g < 2; g++) begin
      check_eq($sformatf("midrst_no_done%0d", g), 32'(done_cnt[g]), 32'd0);
      check_eq($sformatf("midrst_idle_busy%0d", g), 32'(busy[g]), 32'd0);
      check_eq($sformatf("midrst_idle_valid%0d", g), 32'(res_valid[g]), 32'd0);
    end

    cur_mode = MODE_U8;
    push_exp(4'd0, 32'h16);
    do_run(MODE_U8, 4'd0, 5'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
Sequencer for the operand-RAM / multiplier datapath.
On start, walks a window of RAM addresses and fetches the operand pair {mem[addr], mem[addr+1]} at each step. It selects the multiplier (unsigned 8x8, signed radix-4 8x8, or signed 16x16), waits out the multiplier latency and captures the product. Each product goes to a downstream consumer (hex display register or bench) over a valid/ready handshake.
Sits between the front-panel controls (KEY/SW) and the existing ram / multiplier / display instances.

Parameters:
MULT_LAT, 0, extra clock cycles between op_a/op_b valid and product valid (0 = combinational multiplier)
ADDR_W, 4, RAM address width; the window wraps modulo 2^ADDR_W
DATA_W, 32, operand and product width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a run; sampled only in IDLE
mode  in  2  00 unsigned 8x8, 01 signed 8x8, 11 signed 16x16, 10 illegal
base_addr  in  ADDR_W  first RAM address of the window
count  in  ADDR_W+1  number of products to generate (0..16)
ram_addr  out  ADDR_W  address to the RAM; RAM returns mem[ram_addr] and mem[ram_addr+1] one clock later
op_a  in  DATA_W  RAM data_out1
op_b  in  DATA_W  RAM data_out2
mul_sel  out  2  multiplier/result mux select (mode latched at start)
product  in  DATA_W  selected multiplier output
res_data  out  DATA_W  captured product
res_valid  out  1  res_data valid
res_ready  in  1  consumer accepts res_data
busy  out  1  high from the cycle after start is accepted until DONE is left
done  out  1  one-cycle pulse at end of run
err_mode  out  1  sticky illegal-mode flag; cleared on the next accepted start

Behaviour:
- Reset (async assert, sync release): state IDLE. ram_addr=0, mul_sel=0, res_data=0, res_valid=0, busy=0, done=0, err_mode=0. Internal step counter and latency counter = 0.
- Reset mid-run: the run is abandoned and there is no done pulse.
- FSM: IDLE, FETCH, RDWAIT, MULW, OUT, DONE.
- IDLE: when start=1, latch mode, base_addr and count, and clear err_mode.
  - mode=10: set err_mode and go to DONE; no RAM or multiplier activity.
  - count=0: go to DONE.
  - Otherwise: ram_addr<=base_addr, mul_sel<=mode, go to FETCH.
- FETCH: one cycle with ram_addr stable, then RDWAIT.
- RDWAIT: op_a/op_b are valid this cycle.
  - MULT_LAT=0: res_data<=product, res_valid<=1, go to OUT.
  - Otherwise: load the latency counter with MULT_LAT and go to MULW.
- MULW: decrement the counter each cycle. In the cycle it reads 1, capture product and go to OUT.
- OUT: hold res_data and res_valid stable until res_valid & res_ready; on that edge res_valid<=0.
  - If steps remain: ram_addr<=ram_addr+1 (wraps 15->0), go to FETCH.
  - Otherwise: go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency: start sampled at edge E0 gives res_valid high after edge E0+3+MULT_LAT. Each further product takes 3+MULT_LAT cycles after the previous handshake.
- ram_addr and mul_sel are held constant from FETCH through OUT of each step.
- start while busy is ignored. Changes to mode, base_addr or count during a run are ignored.
- Window wrap: with base=15, the first pair is mem[15], mem[0] (RAM-side wrap).
- Product width rules: the multiplier owns sign handling. The sequencer captures all DATA_W bits unmodified.

Optional Feature:
MULT_SEQ_ACC_EN: adds output acc_out[DATA_W-1:0].
- acc_out is cleared on an accepted start and adds each product at its res_valid&res_ready handshake, modulo 2^DATA_W. It is valid once done pulses.
- Without the macro, acc_out does not exist and no adder is synthesised.

Decomposition:
- Package mult_seq_pkg holds:
  - mode constants MODE_U8=2'b00, MODE_S8=2'b01, MODE_ILL=2'b10, MODE_S16=2'b11;
  - state encodings for the six FSM states;
  - the default DATA_W.
- One sub-module is natural: mult_seq_outreg, the res_data/res_valid holding register with handshake. The FSM stays in the top.

Test Plan:
- RAM model preloaded with mem0=1, mem1=22, mem2=0xFFFFFFF7, mem3=0xFFFFFFF6, mem4=9, mem5=24, mem6=31.
- Run 1: mode=00, base=0, count=1, MULT_LAT=0, res_ready=1 -> one res_data=0x16 three cycles after start; done pulses; busy back to 0.
- Run 2: mode=00, base=2, count=1 -> res_data=0xED5A (247*246). Run 3: mode=01, same window -> res_data=0x5A (-9*-10).
- Run 4: mode=11, base=3, count=3 -> res_data sequence 0xFFFFFFA6, 0xD8, 0x2E8; ram_addr sequence 3, 4, 5. With MULT_SEQ_ACC_EN, acc_out=0x366 at done.
- Run 5: mode=10, start -> err_mode=1 and done pulses; res_valid never asserts. Next start with mode=00 -> err_mode cleared.
- Run 6: MULT_LAT=2, res_ready held low 5 cycles -> res_data stays stable while res_valid=1. A start pulse during the run is ignored. Then assert rst_n=0 mid-run -> all outputs return to their reset values immediately and there is no done pulse.
